// File: rtl/banked_mem_responder_pkg.sv
// Shared constants and request classification for the banked memory responder.
package banked_mem_responder_pkg;

  localparam int NUM_BANKS     = 4;
  localparam int BANK_SEL_LSB  = 1;
  localparam int BANK_SEL_MSB  = 2;
  localparam int ROW_LSB       = 3;
  localparam int DEF_BANK_BUSY = 4;
  localparam int DEF_RD_LAT    = 2;
  localparam int CNT_W         = 3;

  typedef enum logic [1:0] {
    REQ_NONE   = 2'd0,
    REQ_ERR    = 2'd1,
    REQ_STALL  = 2'd2,
    REQ_ACCEPT = 2'd3
  } req_kind_e;

  // Illegal requests win over a busy bank, so an illegal request never stalls.
  function automatic req_kind_e classify(input logic rd, input logic wr,
                                         input logic a0, input logic bank_busy);
    req_kind_e k;
    if (!(rd | wr))              k = REQ_NONE;
    else if ((rd & wr) | a0)     k = REQ_ERR;
    else if (bank_busy)          k = REQ_STALL;
    else                         k = REQ_ACCEPT;
    return k;
  endfunction

endpackage

// File: rtl/banked_mem_responder_mem_bank.sv
// One memory bank: word storage with a synchronous write and an asynchronous
// read port, plus the down-counter that holds the bank busy after an access.
module mem_bank
  import banked_mem_responder_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ROW_W     = 13,
  parameter int BANK_BUSY = DEF_BANK_BUSY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_i,
  input  logic              we_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o
);

  // Storage is deliberately outside the reset domain: contents survive reset.
  logic [DATA_W-1:0] mem_q [2**ROW_W];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // Write the addressed word when a write is accepted to this bank.
  always_ff @(posedge clk) begin
    if (acc_i && we_i) mem_q[row_i] <= wdata_i;
  end

  assign rdata_o = mem_q[row_i];

  // Reload on an accepted access (reload wins over decrement), else count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (acc_i)              cnt_d = CNT_W'(BANK_BUSY);
    else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
  end

  // Busy counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-addressed memory responder: decodes each request into
// error / stall / accept, steers it to the bank on addr[2:1], and returns
// read data through a fixed-latency valid+data shift register.
module banked_mem_responder
  import banked_mem_responder_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BANK_BUSY = DEF_BANK_BUSY,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int ROW_W = ADDR_W - ROW_LSB;

  logic [1:0]           bank_sel;
  logic [ROW_W-1:0]     row;
  logic [NUM_BANKS-1:0] busy_w;
  logic [NUM_BANKS-1:0] acc_w;
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
  logic [DATA_W-1:0]    rd_word;
  logic                 accept;
  logic                 rd_acc;
  req_kind_e            kind;

  logic [RD_LAT-1:0]    pipe_vld_q;
  logic [RD_LAT-1:0]    pipe_vld_d;
  logic [DATA_W-1:0]    pipe_dat_q [RD_LAT];
  logic [DATA_W-1:0]    pipe_dat_d [RD_LAT];

  assign bank_sel = addr[BANK_SEL_MSB:BANK_SEL_LSB];
  assign row      = addr[ADDR_W-1:ROW_LSB];

  // Requests are masked while reset is held so nothing is written or flagged.
  assign kind   = classify(rd & rst, wr & rst, addr[0], busy_w[bank_sel]);
  assign err    = (kind == REQ_ERR);
  assign stall  = (kind == REQ_STALL);
  assign accept = (kind == REQ_ACCEPT);
  assign rd_acc = accept & rd;

  // One-hot accept strobe toward the selected bank.
  always_comb begin
    acc_w           = '0;
    acc_w[bank_sel] = accept;
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank #(
      .DATA_W    (DATA_W),
      .ROW_W     (ROW_W),
      .BANK_BUSY (BANK_BUSY)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst),
      .acc_i   (acc_w[g]),
      .we_i    (wr),
      .row_i   (row),
      .wdata_i (data_in),
      .rdata_o (bank_rdata[g]),
      .busy_o  (busy_w[g])
    );
  end

  assign rd_word = bank_rdata[bank_sel];

  // Next state of the read-return shift register: stage 0 captures the accepted read.
  always_comb begin
    pipe_vld_d[0] = rd_acc;
    pipe_dat_d[0] = rd_word;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
  end

  // Valid bits are reset so an in-flight read is dropped by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe_vld_q <= '0;
    else      pipe_vld_q <= pipe_vld_d;
  end

  // Data stages carry no reset; they are only observed through the valid bits.
  always_ff @(posedge clk) begin
    pipe_dat_q <= pipe_dat_d;
  end

  assign data_out = pipe_vld_q[RD_LAT-1] ? pipe_dat_q[RD_LAT-1] : '0;
  assign busy     = busy_w;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench for banked_mem_responder with a read-return scoreboard.
module tb_banked_mem_responder;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [15:0] d;
  } exp_t;
  exp_t sbq[$];

  banked_mem_responder #(
    .ADDR_W(16), .DATA_W(16), .BANK_BUSY(4), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out), .stall(stall), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Finish the current cycle: check the read-return port mid-cycle, then advance.
  task automatic cycle_end();
    @(negedge clk);
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      chk("rdata", {16'h0, data_out}, {16'h0, sbq[0].d});
      void'(sbq.pop_front());
    end else begin
      chk("rdata_idle", {16'h0, data_out}, 32'h0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; data_in = d;
    #1;
  endtask

  task automatic push_rd(input logic [15:0] d);
    exp_t e;
    e.due = cyc + RD_LAT;
    e.d   = d;
    sbq.push_back(e);
  endtask

  initial begin
    // Reset held with a read pending
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h1230, 16'h0);
    @(posedge clk);
    #1;
    chk("rst_busy", {28'h0, busy}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    cycle_end();
    cycle_end();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b1;
    cycle_end();
    cycle_end();

    // Line write
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'h1230 + 16'(2*i), 16'h00A0 + 16'(i));
      chk("lw_stall", {31'h0, stall}, 32'h0);
      chk("lw_err", {31'h0, err}, 32'h0);
      cycle_end();
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    chk("lw_busy4", {28'h0, busy}, 32'hF);
    cycle_end();
    chk("lw_busy5", {28'h0, busy}, 32'hE);
    cycle_end();
    chk("lw_busy6", {28'h0, busy}, 32'hC);
    cycle_end();
    chk("lw_busy7", {28'h0, busy}, 32'h8);
    cycle_end();
    chk("lw_busy8", {28'h0, busy}, 32'h0);

    // Line read back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h1230 + 16'(2*i), 16'h0);
      chk("lr_stall", {31'h0, stall}, 32'h0);
      push_rd(16'h00A0 + 16'(i));
      cycle_end();
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) cycle_end();
    chk("lr_busy_idle", {28'h0, busy}, 32'h0);

    // Preload two rows of bank 0 with known data
    drive(1'b0, 1'b1, 16'h0010, 16'h1111);
    cycle_end();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) cycle_end();
    drive(1'b0, 1'b1, 16'h0018, 16'h2222);
    chk("pre_stall", {31'h0, stall}, 32'h0);
    cycle_end();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) cycle_end();

    // Bank conflict
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    chk("bc_first", {31'h0, stall}, 32'h0);
    push_rd(16'h1111);
    cycle_end();
    drive(1'b1, 1'b0, 16'h0018, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("bc_stall", {31'h0, stall}, 32'h1);
      cycle_end();
    end
    chk("bc_accept", {31'h0, stall}, 32'h0);
    push_rd(16'h2222);
    cycle_end();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 6; i++) cycle_end();

    // Illegal requests
    drive(1'b1, 1'b1, 16'h0002, 16'h5555);
    chk("il_rdwr_err", {31'h0, err}, 32'h1);
    chk("il_rdwr_stall", {31'h0, stall}, 32'h0);
    cycle_end();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    chk("il_busy", {28'h0, busy}, 32'h0);
    drive(1'b1, 1'b0, 16'h0003, 16'h0);
    chk("il_odd_err", {31'h0, err}, 32'h1);
    cycle_end();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    chk("il_busy2", {28'h0, busy}, 32'h0);
    for (int i = 0; i < 3; i++) cycle_end();

    // Reset during an in-flight read
    drive(1'b1, 1'b0, 16'h1230, 16'h0);
    chk("rm_accept", {31'h0, stall}, 32'h0);
    cycle_end();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    chk("rm_busy", {28'h0, busy}, 32'h0);
    cycle_end();
    cycle_end();
    rst = 1'b1;
    cycle_end();
    drive(1'b1, 1'b0, 16'h1230, 16'h0);
    chk("rm_re_stall", {31'h0, stall}, 32'h0);
    push_rd(16'h00A0);
    cycle_end();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) cycle_end();

    chk("sb_empty", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
